// File: rtl/stopwatch_core.sv
// stopwatch_core: two-digit (00-99) BCD stopwatch with a multiplexed
// seven-segment display driver.
//
// Parameters:
//   TICK_DIV  clk cycles per one-second count tick (>= 2)
//   SCAN_DIV  clk cycles per display digit slot    (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   one_pulse    single-cycle request: ones digit +1 (PAUSE only)
//   ten_pulse    single-cycle request: tens digit +1 (PAUSE only)
//   pause_pulse  single-cycle request: toggle RUN/PAUSE
//   clear_pulse  single-cycle request: zero count and prescaler, force PAUSE
//   ssd[7:0]     active-high segments {dp,g,f,e,d,c,b,a} of the selected digit
//   digit_en     active-high digit enable (2'b01 = ones, 2'b10 = tens)
//
// Optional feature macro: SSD_DP_BLINK_EN
//   When defined, the decimal point is lit in RUN during the first half of
//   each prescaler period. When undefined, ssd[7] is tied to 0.

module stopwatch_core #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       one_pulse,
  input  logic       ten_pulse,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  output logic [7:0] ssd,
  output logic [1:0] digit_en
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          run;
  logic          tick;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;

  logic [3:0]    digit_val;
  logic [6:0]    seg;
  logic          dp;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_PAUSE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // clear wins over pause; a pause coincident with a tick still toggles,
  // the tick being applied by the datapath in the same edge.
  always_comb begin
    state_d = state_q;
    if (clear_pulse) begin
      state_d = ST_PAUSE;
    end else if (pause_pulse) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run = (state_q == ST_RUN);
  end

  assign tick = run && (presc_q == PRESC_LAST);

  // ---------------- Prescaler and BCD count ----------------
  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    if (clear_pulse) begin
      presc_d = '0;
      ones_d  = '0;
      tens_d  = '0;
    end else begin
      if (run) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        if (ones_q == 4'd9) begin
          ones_d = '0;
          tens_d = (tens_q == 4'd9) ? '0 : tens_q + 1'b1;
        end else begin
          ones_d = ones_q + 1'b1;
        end
      end else if (!run) begin
        // Manual set: each digit wraps independently, no carry.
        if (one_pulse) ones_d = (ones_q == 4'd9) ? '0 : ones_q + 1'b1;
        if (ten_pulse) tens_d = (tens_q == 4'd9) ? '0 : tens_q + 1'b1;
      end
    end
  end

  // ---------------- Display scan ----------------
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    sel_d  = (scan_q == SCAN_LAST) ? ~sel_q : sel_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_q <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
    end
  end

  // ---------------- Segment decode ----------------
  assign digit_val = sel_q ? tens_q : ones_q;

  always_comb begin
    seg = 7'h00;
    case (digit_val)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

`ifdef SSD_DP_BLINK_EN
  assign dp = run && (presc_q < PW'(TICK_DIV / 2));
`else
  assign dp = 1'b0;
`endif

  assign ssd      = {dp, seg};
  assign digit_en = sel_q ? 2'b10 : 2'b01;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 10000000, SHALL set the clk cycles per one-second count tick (min 2).
REQ-002 Parameter SCAN_DIV, default 10000, SHALL set the clk cycles per display digit slot (min 2).
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 one_pulse  input  1  SHALL be a single-cycle, already-synchronized request to increment the ones digit.
REQ-006 ten_pulse  input  1  SHALL be a single-cycle, already-synchronized request to increment the tens digit.
REQ-007 pause_pulse  input  1  SHALL be a single-cycle, already-synchronized request to toggle RUN/PAUSE.
REQ-008 clear_pulse  input  1  SHALL be a single-cycle, already-synchronized request to zero the count.
REQ-009 ssd  output  8  SHALL carry the active-high segments {dp,g,f,e,d,c,b,a} of the currently selected digit.
REQ-010 digit_en  output  2  SHALL carry the active-high digit enable: 2'b01 = ones, 2'b10 = tens; exactly one bit set at all times.

Function
REQ-011 The count SHALL be two BCD registers, ones and tens, each 0-9; the displayed value is 00-99.
REQ-012 The state machine SHALL have two states, PAUSE and RUN.
REQ-013 pause_pulse SHALL toggle the state (PAUSE->RUN, RUN->PAUSE) on the next edge.
REQ-014 The prescaler SHALL count only in RUN, hold its value in PAUSE, and produce a one-cycle tick when it equals TICK_DIV-1, then return to 0.
REQ-015 On a tick, the count SHALL increment by one in BCD: ones 9->0 carries into tens; 99 wraps to 00.
REQ-016 In PAUSE, one_pulse SHALL increment ones mod 10 (9->0, no carry) and ten_pulse SHALL increment tens mod 10.
REQ-017 In RUN, one_pulse and ten_pulse SHALL be ignored.
REQ-018 clear_pulse SHALL, on the next edge, set ones=tens=0, zero the prescaler and force PAUSE.
REQ-019 Priority SHALL be clear_pulse > tick/digit pulses > pause_pulse.
- A pause_pulse coincident with a tick SHALL apply the tick and then change state.
- A pause_pulse coincident with clear_pulse SHALL be ignored.
REQ-020 one_pulse and ten_pulse in the same PAUSE cycle SHALL both apply independently.
REQ-021 The scan counter SHALL run free in both states and toggle the digit select when it equals SCAN_DIV-1, then return to 0.
REQ-022 ssd[6:0] SHALL be a combinational decode of the selected digit's BCD value using standard patterns (0=7'h3F, 1=7'h06, ... 9=7'h6F), with zero latency from the registered digit select and count.
REQ-023 digit_en SHALL be driven directly from the registered digit select.

Reset
REQ-024 While n_rst=0, the block SHALL be in PAUSE with ones=tens=0, prescaler=0, scan counter=0 and digit select=ones, regardless of clk.
REQ-025 Outputs in reset SHALL be ssd=8'h3F and digit_en=2'b01.
REQ-026 Reset asserted mid-count SHALL discard all state; after release the block SHALL wait in PAUSE for pause_pulse.

Configuration
REQ-027 When SSD_DP_BLINK_EN is defined, ssd[7] SHALL be 1 in RUN during the first half of each prescaler period (prescaler < TICK_DIV/2) and 0 otherwise, for both digits.
REQ-028 When SSD_DP_BLINK_EN is undefined, ssd[7] SHALL be constant 0 and no blink logic SHALL be synthesized.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-029 Release reset, idle 20 cycles -> count stays 00, ssd=8'h3F on both digits, digit_en alternates 01/10 every 2 cycles.
REQ-030 pause_pulse, then 40 cycles -> count=10 (tens slot ssd=8'h06, ones slot ssd=8'h3F).
REQ-031 Preload 99 via one/ten pulses in PAUSE, then RUN 4 cycles -> wrap to 00; 9 one_pulses in PAUSE from 09 -> 08 with tens unchanged.
REQ-032 clear_pulse and pause_pulse in the same cycle while RUN at 37 -> count 00, state PAUSE, prescaler 0.
REQ-033 pause_pulse coincident with a tick at 05 -> count 06 and state PAUSE; one_pulse while RUN -> no change.
REQ-034 With SSD_DP_BLINK_EN defined in RUN -> ssd[7]=1 for prescaler 0-1 and 0 for prescaler 2-3; in PAUSE or with the macro undefined -> ssd[7]=0.
